// File: rtl/spgd_pkg.sv
// Shared defaults, FSM state type and LOG2_N clamp helper for the ADC block averager.
package spgd_pkg;

    localparam int ADC_WIDTH_DEF  = 12;
    localparam int MAX_LOG2_N_DEF = 10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_ACCUM,
        ST_OUTPUT
    } state_t;

    function automatic logic [3:0] clamp_log2n(input logic [3:0] req, input logic [3:0] max_l2);
        return (req > max_l2) ? max_l2 : req;
    endfunction

endpackage

// File: rtl/adc_block_average_avg_round_sat.sv
// Combinational round-half-up divide by 2^log2_n, saturated to the sample width.
module avg_round_sat
    import spgd_pkg::*;
#(
    parameter int ADC_WIDTH  = ADC_WIDTH_DEF,
    parameter int MAX_LOG2_N = MAX_LOG2_N_DEF
) (
    input  logic [ADC_WIDTH+MAX_LOG2_N-1:0] i_sum,
    input  logic [3:0]                      i_log2_n,
    output logic [ADC_WIDTH-1:0]            o_mean
);

    localparam int             SUM_W = ADC_WIDTH + MAX_LOG2_N;
    localparam logic [SUM_W:0] ONE   = 1;

    logic [SUM_W:0] w_half;
    logic [SUM_W:0] w_biased;
    logic [SUM_W:0] w_shifted;

    // One spare bit keeps sum + half from wrapping before the shift.
    always_comb begin
        w_half    = (i_log2_n == 4'd0) ? '0 : (ONE << (i_log2_n - 4'd1));
        w_biased  = {1'b0, i_sum} + w_half;
        w_shifted = w_biased >> i_log2_n;
        o_mean    = (|w_shifted[SUM_W:ADC_WIDTH]) ? '1 : w_shifted[ADC_WIDTH-1:0];
    end

endmodule

// File: rtl/adc_block_average.sv
// Block averager: optional settle discard, 2^LOG2_N sample accumulation, rounded mean
// and raw sum published with a one-cycle valid pulse; optional continuous re-arm.
module adc_block_average
    import spgd_pkg::*;
#(
    parameter int ADC_WIDTH    = ADC_WIDTH_DEF,
    parameter int MAX_LOG2_N   = MAX_LOG2_N_DEF,
    parameter int SETTLE_WIDTH = 8
) (
    input  logic                            ADC_CLK,
    input  logic                            RST_N,
    input  logic [ADC_WIDTH-1:0]            ADC_DATA_IN,
    input  logic                            START,
    input  logic                            CONT,
    input  logic [3:0]                      LOG2_N,
    input  logic [SETTLE_WIDTH-1:0]         SETTLE,
    output logic [ADC_WIDTH-1:0]            AVG_OUT,
    output logic [ADC_WIDTH+MAX_LOG2_N-1:0] SUM_OUT,
    output logic                            AVG_VALID,
    output logic                            BUSY
);

    localparam int                      SUM_W    = ADC_WIDTH + MAX_LOG2_N;
    localparam int                      CNT_W    = MAX_LOG2_N;
    localparam logic [3:0]              MAX_L2   = 4'(MAX_LOG2_N);
    localparam logic [CNT_W-1:0]        CNT_ONE  = 1;
    localparam logic [CNT_W-1:0]        CNT_ONES = '1;
    localparam logic [SETTLE_WIDTH-1:0] SET_ONE  = 1;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [3:0]              r_log2n;
    logic [SETTLE_WIDTH-1:0] r_settle_cnt;
    logic [CNT_W-1:0]        r_samp_cnt;
    logic [SUM_W-1:0]        r_acc;
    logic [ADC_WIDTH-1:0]    r_avg_out;
    logic [SUM_W-1:0]        r_sum_out;
    logic                    r_avg_valid;

    logic [CNT_W-1:0]        w_samp_last;
    logic [SUM_W-1:0]        w_sample_ext;
    logic [ADC_WIDTH-1:0]    w_mean;
    logic                    w_settle_done;
    logic                    w_accum_done;
    logic                    w_busy;
    logic                    w_latch_cfg;
    logic                    w_enter_accum;
    logic                    w_publish;

    // Last sample index of the block is N-1, i.e. the low r_log2n bits all set.
    always_comb begin
        w_samp_last   = CNT_ONES >> (MAX_L2 - r_log2n);
        w_sample_ext  = {{MAX_LOG2_N{1'b0}}, ADC_DATA_IN};
        w_settle_done = (r_settle_cnt == SET_ONE);
        w_accum_done  = (r_state == ST_ACCUM) && (r_samp_cnt == w_samp_last);
    end

    always_ff @(posedge ADC_CLK) begin
        if (!RST_N) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (START) begin
                    w_state_next = (SETTLE != '0) ? ST_SETTLE : ST_ACCUM;
                end
            end
            ST_SETTLE: begin
                if (w_settle_done) begin
                    w_state_next = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (w_accum_done) begin
                    w_state_next = ST_OUTPUT;
                end
            end
            ST_OUTPUT: begin
                w_state_next = CONT ? ST_ACCUM : ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        w_busy        = (r_state != ST_IDLE);
        w_latch_cfg   = (r_state == ST_IDLE) && START;
        w_enter_accum = (w_state_next == ST_ACCUM) && (r_state != ST_ACCUM);
        w_publish     = (r_state == ST_OUTPUT);
    end

    always_ff @(posedge ADC_CLK) begin
        if (!RST_N) begin
            r_log2n      <= '0;
            r_settle_cnt <= '0;
            r_samp_cnt   <= '0;
            r_acc        <= '0;
            r_avg_out    <= '0;
            r_sum_out    <= '0;
            r_avg_valid  <= 1'b0;
        end else begin
            r_avg_valid <= w_publish;

            if (w_latch_cfg) begin
                r_log2n      <= clamp_log2n(LOG2_N, MAX_L2);
                r_settle_cnt <= SETTLE;
            end else if (r_state == ST_SETTLE) begin
                r_settle_cnt <= r_settle_cnt - SET_ONE;
            end

            // Entry into ACCUM (from IDLE, SETTLE or a continuous OUTPUT) starts a fresh block.
            if (w_enter_accum) begin
                r_acc      <= '0;
                r_samp_cnt <= '0;
            end else if (r_state == ST_ACCUM) begin
                r_acc      <= r_acc + w_sample_ext;
                r_samp_cnt <= r_samp_cnt + CNT_ONE;
            end

            if (w_publish) begin
                r_avg_out <= w_mean;
                r_sum_out <= r_acc;
            end
        end
    end

    avg_round_sat #(
        .ADC_WIDTH  (ADC_WIDTH),
        .MAX_LOG2_N (MAX_LOG2_N)
    ) u_round (
        .i_sum    (r_acc),
        .i_log2_n (r_log2n),
        .o_mean   (w_mean)
    );

    assign AVG_OUT   = r_avg_out;
    assign SUM_OUT   = r_sum_out;
    assign AVG_VALID = r_avg_valid;
    assign BUSY      = w_busy;

endmodule

// File: tb/tb_adc_block_average.sv
// Self-checking bench for adc_block_average: directed cases plus randomized runs against an
// edge-scheduled reference model of the block timing and arithmetic.
module tb_adc_block_average;

    localparam int AW   = 12;
    localparam int ML   = 10;
    localparam int SW   = 8;
    localparam int SUMW = AW + ML;
    localparam int MAXE = 2048;

    logic            ADC_CLK = 1'b0;
    logic            RST_N;
    logic            START;
    logic            CONT;
    logic [AW-1:0]   ADC_DATA_IN;
    logic [3:0]      LOG2_N;
    logic [SW-1:0]   SETTLE;
    logic [AW-1:0]   AVG_OUT;
    logic [SUMW-1:0] SUM_OUT;
    logic            AVG_VALID;
    logic            BUSY;

    int n_checks = 0;
    int n_fail   = 0;

    // Per-edge stimulus: entry e is applied to the inputs before rising edge e of a scenario.
    logic [AW-1:0]   data_arr [MAXE];
    bit              start_arr[MAXE];
    bit              cont_arr [MAXE];
    bit              rst_arr  [MAXE];
    logic [3:0]      l2_arr   [MAXE];
    logic [SW-1:0]   set_arr  [MAXE];

    // Outputs observed just after edge e, and what the model predicts for them.
    bit              valid_obs[MAXE];
    bit              busy_obs [MAXE];
    logic [AW-1:0]   avg_obs  [MAXE];
    logic [SUMW-1:0] sum_obs  [MAXE];
    bit              exp_valid[MAXE];
    bit              exp_busy [MAXE];
    logic [AW-1:0]   exp_avg  [MAXE];
    logic [SUMW-1:0] exp_sum  [MAXE];
    logic [AW-1:0]   m_avg;
    logic [SUMW-1:0] m_sum;

    always #5 ADC_CLK = ~ADC_CLK;

    adc_block_average #(
        .ADC_WIDTH    (AW),
        .MAX_LOG2_N   (ML),
        .SETTLE_WIDTH (SW)
    ) dut (
        .ADC_CLK     (ADC_CLK),
        .RST_N       (RST_N),
        .ADC_DATA_IN (ADC_DATA_IN),
        .START       (START),
        .CONT        (CONT),
        .LOG2_N      (LOG2_N),
        .SETTLE      (SETTLE),
        .AVG_OUT     (AVG_OUT),
        .SUM_OUT     (SUM_OUT),
        .AVG_VALID   (AVG_VALID),
        .BUSY        (BUSY)
    );

    task automatic clear_stim();
        for (int i = 0; i < MAXE; i++) begin
            data_arr[i]  = '0;
            start_arr[i] = 1'b0;
            cont_arr[i]  = 1'b0;
            rst_arr[i]   = 1'b0;
            l2_arr[i]    = '0;
            set_arr[i]   = '0;
        end
    endtask

    task automatic run(input int n);
        for (int e = 0; e < n; e++) begin
            ADC_DATA_IN = data_arr[e];
            START       = start_arr[e];
            CONT        = cont_arr[e];
            RST_N       = !rst_arr[e];
            LOG2_N      = l2_arr[e];
            SETTLE      = set_arr[e];
            @(posedge ADC_CLK);
            #1;
            valid_obs[e] = AVG_VALID;
            busy_obs[e]  = BUSY;
            avg_obs[e]   = AVG_OUT;
            sum_obs[e]   = SUM_OUT;
            if (AVG_VALID) begin
                $display("edge %0d: result avg=%h sum=%h", e, AVG_OUT, SUM_OUT);
            end
        end
        START = 1'b0;
        CONT  = 1'b0;
        RST_N = 1'b1;
    endtask

    function automatic longint block_sum(input int first, input int n);
        longint s = 0;
        for (int i = 0; i < n; i++) begin
            s += longint'(data_arr[first + i]);
        end
        return s;
    endfunction

    function automatic logic [AW-1:0] mean_of(input longint s, input int l2);
        longint n;
        longint m;
        n = longint'(1) << l2;
        m = (s + n / 2) / n;
        if (m > 4095) m = 4095;
        return AW'(m);
    endfunction

    function automatic int count_valid(input int lo, input int hi);
        int c = 0;
        for (int i = lo; i <= hi; i++) begin
            if (valid_obs[i]) c++;
        end
        return c;
    endfunction

    // Schedules blocks by arithmetic: START at edge k, settle S, length N -> samples at
    // edges first..first+N-1 (first = k+S+1), result at edge first+N; CONT there re-arms.
    task automatic model_run(input int n);
        int     e, k, first, v, nn, r, lim, l2;
        bit     stop;
        longint s;
        for (int i = 0; i < n; i++) begin
            exp_valid[i] = 1'b0;
            exp_busy[i]  = 1'b0;
        end
        e = 0;
        while (e < n) begin
            if (rst_arr[e]) begin
                m_avg = '0;
                m_sum = '0;
                exp_avg[e] = '0;
                exp_sum[e] = '0;
                e++;
            end else if (!start_arr[e]) begin
                exp_avg[e] = m_avg;
                exp_sum[e] = m_sum;
                e++;
            end else begin
                l2    = (l2_arr[e] > 4'd10) ? 10 : int'(l2_arr[e]);
                nn    = 1 << l2;
                k     = e;
                first = e + int'(set_arr[e]) + 1;
                stop  = 1'b0;
                while (!stop) begin
                    v = first + nn;
                    r = -1;
                    for (int i = k + 1; i <= v && i < n; i++) begin
                        if (rst_arr[i] && r < 0) r = i;
                    end
                    lim = (r >= 0) ? r : v;
                    for (int i = k; i < lim && i < n; i++) begin
                        exp_busy[i] = 1'b1;
                        exp_avg[i]  = m_avg;
                        exp_sum[i]  = m_sum;
                    end
                    if (r >= 0) begin
                        e    = r;
                        stop = 1'b1;
                    end else if (v >= n) begin
                        e    = n;
                        stop = 1'b1;
                    end else begin
                        s            = block_sum(first, nn);
                        m_sum        = SUMW'(s);
                        m_avg        = mean_of(s, l2);
                        exp_valid[v] = 1'b1;
                        exp_avg[v]   = m_avg;
                        exp_sum[v]   = m_sum;
                        exp_busy[v]  = cont_arr[v];
                        if (cont_arr[v]) begin
                            k     = v;
                            first = v + 1;
                        end else begin
                            e    = v + 1;
                            stop = 1'b1;
                        end
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        clear_stim();
        for (int i = 0; i < 3; i++) begin
            rst_arr[i]   = 1'b1;
            start_arr[i] = 1'b1;
            data_arr[i]  = AW'($urandom);
        end
        run(4);
        n_checks++; if (avg_obs[2] !== '0)  begin n_fail++; $display("FAIL reset_avg: got %h expected 0", avg_obs[2]); end
        n_checks++; if (sum_obs[2] !== '0)  begin n_fail++; $display("FAIL reset_sum: got %h expected 0", sum_obs[2]); end
        n_checks++; if (valid_obs[2] !== 0) begin n_fail++; $display("FAIL reset_valid: got %0b expected 0", valid_obs[2]); end
        n_checks++; if (busy_obs[2] !== 0)  begin n_fail++; $display("FAIL reset_busy: got %0b expected 0", busy_obs[2]); end
        n_checks++; if (busy_obs[3] !== 0)  begin n_fail++; $display("FAIL reset_idle_after: busy %0b expected 0", busy_obs[3]); end
    endtask

    task automatic test_const_full_block();
        clear_stim();
        for (int i = 0; i < 1030; i++) data_arr[i] = 12'h800;
        start_arr[0] = 1'b1;
        l2_arr[0]    = 4'd10;
        run(1030);
        n_checks++; if (count_valid(0, 1029) !== 1) begin n_fail++; $display("FAIL const_pulses: got %0d expected 1", count_valid(0, 1029)); end
        n_checks++; if (valid_obs[1025] !== 1'b1) begin n_fail++; $display("FAIL const_valid_edge: valid at 1025 is %0b expected 1", valid_obs[1025]); end
        n_checks++; if (avg_obs[1025] !== 12'h800) begin n_fail++; $display("FAIL const_avg: got %h expected 800", avg_obs[1025]); end
        n_checks++; if (sum_obs[1025] !== 22'h200000) begin n_fail++; $display("FAIL const_sum: got %h expected 200000", sum_obs[1025]); end
        n_checks++; if (avg_obs[1024] !== '0) begin n_fail++; $display("FAIL const_hold: avg before pulse %h expected 0", avg_obs[1024]); end
        n_checks++; if (busy_obs[1024] !== 1 || busy_obs[1025] !== 0) begin
            n_fail++; $display("FAIL const_busy: busy@1024=%0b busy@1025=%0b expected 1/0", busy_obs[1024], busy_obs[1025]);
        end
    endtask

    task automatic test_rounding();
        clear_stim();
        for (int i = 0; i < 12; i++) data_arr[i] = AW'($urandom);
        start_arr[0] = 1'b1; l2_arr[0] = 4'd1;
        data_arr[1]  = 12'd0; data_arr[2] = 12'd1;
        start_arr[6] = 1'b1; l2_arr[6] = 4'd0;
        data_arr[7]  = 12'h123;
        run(12);
        n_checks++; if (count_valid(0, 11) !== 2) begin n_fail++; $display("FAIL round_pulses: got %0d expected 2", count_valid(0, 11)); end
        n_checks++; if (valid_obs[3] !== 1'b1) begin n_fail++; $display("FAIL round_half_edge: valid@3 %0b expected 1", valid_obs[3]); end
        n_checks++; if (sum_obs[3] !== 22'd1) begin n_fail++; $display("FAIL round_half_sum: got %h expected 1", sum_obs[3]); end
        n_checks++; if (avg_obs[3] !== 12'd1) begin n_fail++; $display("FAIL round_half_avg: got %h expected 1", avg_obs[3]); end
        n_checks++; if (valid_obs[8] !== 1'b1) begin n_fail++; $display("FAIL n1_edge: valid@8 %0b expected 1", valid_obs[8]); end
        n_checks++; if (avg_obs[8] !== 12'h123) begin n_fail++; $display("FAIL n1_avg: got %h expected 123", avg_obs[8]); end
        n_checks++; if (sum_obs[8] !== 22'h123) begin n_fail++; $display("FAIL n1_sum: got %h expected 123", sum_obs[8]); end
    endtask

    task automatic test_saturation();
        clear_stim();
        for (int i = 0; i < 20; i++) data_arr[i] = 12'hFFF;
        start_arr[0] = 1'b1; l2_arr[0] = 4'd4;
        run(20);
        n_checks++; if (valid_obs[17] !== 1'b1) begin n_fail++; $display("FAIL sat_edge: valid@17 %0b expected 1", valid_obs[17]); end
        n_checks++; if (sum_obs[17] !== 22'd65520) begin n_fail++; $display("FAIL sat_sum: got %0d expected 65520", sum_obs[17]); end
        n_checks++; if (avg_obs[17] !== 12'hFFF) begin n_fail++; $display("FAIL sat_avg: got %h expected fff", avg_obs[17]); end
    endtask

    task automatic test_settle_and_restart_ignored();
        clear_stim();
        for (int i = 1; i <= 5; i++) data_arr[i] = 12'hFFF;
        for (int i = 1; i < 30; i++) begin
            l2_arr[i]  = 4'($urandom_range(0, 15));
            set_arr[i] = SW'($urandom_range(0, 9));
        end
        start_arr[0] = 1'b1; l2_arr[0] = 4'd3; set_arr[0] = 8'd5;
        start_arr[8] = 1'b1; l2_arr[8] = 4'd1; set_arr[8] = 8'd0;
        run(30);
        n_checks++; if (count_valid(0, 29) !== 1) begin n_fail++; $display("FAIL settle_pulses: got %0d expected 1", count_valid(0, 29)); end
        n_checks++; if (valid_obs[14] !== 1'b1) begin n_fail++; $display("FAIL settle_edge: valid@14 %0b expected 1", valid_obs[14]); end
        n_checks++; if (avg_obs[14] !== '0) begin n_fail++; $display("FAIL settle_avg: got %h expected 0", avg_obs[14]); end
        n_checks++; if (sum_obs[14] !== '0) begin n_fail++; $display("FAIL settle_sum: got %h expected 0", sum_obs[14]); end
        n_checks++; if (avg_obs[13] !== 12'hFFF) begin n_fail++; $display("FAIL settle_hold: got %h expected fff", avg_obs[13]); end
    endtask

    task automatic test_back_to_back();
        clear_stim();
        for (int i = 0; i < 16; i++) data_arr[i] = AW'($urandom);
        for (int i = 0; i < 4; i++) begin
            data_arr[1 + i] = AW'(i);
            data_arr[6 + i] = AW'(4 + i);
        end
        start_arr[0] = 1'b1; cont_arr[0] = 1'b1; l2_arr[0] = 4'd2;
        cont_arr[5]  = 1'b1;
        run(16);
        n_checks++; if (count_valid(0, 15) !== 2) begin n_fail++; $display("FAIL cont_pulses: got %0d expected 2", count_valid(0, 15)); end
        n_checks++; if (valid_obs[5] !== 1 || valid_obs[10] !== 1) begin
            n_fail++; $display("FAIL cont_edges: valid@5=%0b valid@10=%0b expected 1/1", valid_obs[5], valid_obs[10]);
        end
        n_checks++; if (avg_obs[5] !== 12'd2 || sum_obs[5] !== 22'd6) begin
            n_fail++; $display("FAIL cont_first: avg %0d sum %0d expected 2 6", avg_obs[5], sum_obs[5]);
        end
        n_checks++; if (avg_obs[10] !== 12'd6 || sum_obs[10] !== 22'd22) begin
            n_fail++; $display("FAIL cont_second: avg %0d sum %0d expected 6 22", avg_obs[10], sum_obs[10]);
        end
        n_checks++; if (busy_obs[5] !== 1 || busy_obs[10] !== 0) begin
            n_fail++; $display("FAIL cont_busy: busy@5=%0b busy@10=%0b expected 1/0", busy_obs[5], busy_obs[10]);
        end
    endtask

    task automatic test_reset_mid_block();
        longint s;
        clear_stim();
        for (int i = 0; i < 1100; i++) data_arr[i] = AW'($urandom);
        start_arr[0]   = 1'b1; l2_arr[0] = 4'd10;
        rst_arr[500]   = 1'b1;
        start_arr[500] = 1'b1;
        start_arr[505] = 1'b1; l2_arr[505] = 4'd2; set_arr[505] = 8'd1;
        run(1100);
        s = block_sum(507, 4);
        n_checks++; if (avg_obs[499] !== 12'd6) begin n_fail++; $display("FAIL rstmid_hold: got %h expected 6", avg_obs[499]); end
        n_checks++; if (busy_obs[500] !== 0) begin n_fail++; $display("FAIL rstmid_busy: got %0b expected 0", busy_obs[500]); end
        n_checks++; if (avg_obs[500] !== '0 || sum_obs[500] !== '0) begin
            n_fail++; $display("FAIL rstmid_clear: avg %h sum %h expected 0 0", avg_obs[500], sum_obs[500]);
        end
        n_checks++; if (count_valid(0, 1099) !== 1) begin n_fail++; $display("FAIL rstmid_pulses: got %0d expected 1", count_valid(0, 1099)); end
        n_checks++; if (valid_obs[511] !== 1'b1) begin n_fail++; $display("FAIL rstmid_restart_edge: valid@511 %0b expected 1", valid_obs[511]); end
        n_checks++; if (sum_obs[511] !== SUMW'(s) || avg_obs[511] !== mean_of(s, 2)) begin
            n_fail++; $display("FAIL rstmid_restart_val: avg %h sum %h expected %h %h", avg_obs[511], sum_obs[511], mean_of(s, 2), SUMW'(s));
        end
    endtask

    task automatic test_random();
        int n;
        for (int t = 0; t < 6; t++) begin
            clear_stim();
            n = (t == 5) ? 1200 : 400;
            for (int i = 0; i < n; i++) begin
                data_arr[i]  = AW'($urandom);
                cont_arr[i]  = 1'($urandom_range(0, 1));
                l2_arr[i]    = 4'($urandom_range(0, 6));
                set_arr[i]   = SW'($urandom_range(0, 20));
                start_arr[i] = ($urandom_range(0, 15) == 0);
                rst_arr[i]   = (t < 5) && ($urandom_range(0, 299) == 0);
            end
            rst_arr[0]   = 1'b1;
            start_arr[1] = 1'b1;
            rst_arr[1]   = 1'b0;
            if (t == 5) begin
                l2_arr[1]   = 4'd12;
                cont_arr    = '{default: 1'b0};
            end
            model_run(n);
            run(n);
            for (int i = 0; i < n; i++) begin
                n_checks++; if (valid_obs[i] !== exp_valid[i]) begin
                    n_fail++; $display("FAIL rand_valid t%0d e%0d: got %0b expected %0b", t, i, valid_obs[i], exp_valid[i]);
                end
                n_checks++; if (busy_obs[i] !== exp_busy[i]) begin
                    n_fail++; $display("FAIL rand_busy t%0d e%0d: got %0b expected %0b", t, i, busy_obs[i], exp_busy[i]);
                end
                n_checks++; if (avg_obs[i] !== exp_avg[i]) begin
                    n_fail++; $display("FAIL rand_avg t%0d e%0d: got %h expected %h", t, i, avg_obs[i], exp_avg[i]);
                end
                n_checks++; if (sum_obs[i] !== exp_sum[i]) begin
                    n_fail++; $display("FAIL rand_sum t%0d e%0d: got %h expected %h", t, i, sum_obs[i], exp_sum[i]);
                end
            end
        end
    endtask

    initial begin
        RST_N       = 1'b0;
        START       = 1'b0;
        CONT        = 1'b0;
        ADC_DATA_IN = '0;
        LOG2_N      = '0;
        SETTLE      = '0;
        m_avg       = '0;
        m_sum       = '0;
        test_reset();
        test_const_full_block();
        test_rounding();
        test_saturation();
        test_settle_and_restart_ignored();
        test_back_to_back();
        test_reset_mid_block();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/adc_block_average.md
ADC_BLOCK_AVERAGE -- requirements
Module: adc_block_average

Interface
REQ-001 Parameter ADC_WIDTH, default 12, ADC sample width in bits.
REQ-002 Parameter MAX_LOG2_N, default 10, largest supported log2 of block length (1024 samples).
REQ-003 Parameter SETTLE_WIDTH, default 8, width of the settle-count input.
REQ-004 ADC_CLK  in  1  sole clock; all state updates on rising edge.
REQ-005 RST_N  in  1  reset, synchronous and active-low.
REQ-006 ADC_DATA_IN  in  ADC_WIDTH  unsigned ADC sample, one per clock.
REQ-007 START  in  1  request one averaging block; sampled only in IDLE.
REQ-008 CONT  in  1  continuous mode; back-to-back blocks while high.
REQ-009 LOG2_N  in  4  block length exponent, latched at START.
REQ-010 SETTLE  in  SETTLE_WIDTH  samples discarded before accumulation, latched at START.
REQ-011 AVG_OUT  out  ADC_WIDTH  rounded block mean, held until next result.
REQ-012 SUM_OUT  out  ADC_WIDTH+MAX_LOG2_N  raw block sum, updated with AVG_OUT.
REQ-013 AVG_VALID  out  1  one-cycle pulse marking new AVG_OUT/SUM_OUT.
REQ-014 BUSY  out  1  high in any state other than IDLE.

Function
REQ-015 FSM states SHALL be IDLE, SETTLE, ACCUM, OUTPUT.
REQ-016 IDLE with START=1 at edge k: latch LOG2_N (clamped to MAX_LOG2_N if larger) and SETTLE; next state SETTLE if SETTLE>0, else ACCUM.
REQ-017 SETTLE: count edges; after SETTLE edges go to ACCUM; samples ignored.
REQ-018 ACCUM: add ADC_DATA_IN to accumulator on each edge; after exactly N=2^LOG2_N samples go to OUTPUT.
REQ-019 Accumulator SHALL be ADC_WIDTH+MAX_LOG2_N bits, cleared on entry to ACCUM; no overflow possible.
REQ-020 With SETTLE=S, last sample taken at edge k+S+N; AVG_VALID high during the cycle after edge k+S+N+1 only.
REQ-021 AVG_OUT = (sum + 2^(LOG2_N-1)) >> LOG2_N, saturated to 2^ADC_WIDTH-1; for LOG2_N=0 AVG_OUT = sum.
REQ-022 OUTPUT lasts one cycle; next state ACCUM if CONT=1 (no settle, accumulator cleared, latched LOG2_N reused), else IDLE.
REQ-023 START outside IDLE SHALL be ignored; LOG2_N/SETTLE changes outside IDLE have no effect.
REQ-024 START and CONT both high in IDLE: behaves as START; CONT sampled only in OUTPUT.
REQ-025 AVG_OUT and SUM_OUT SHALL change only on the edge that asserts AVG_VALID.

Reset
REQ-026 RST_N=0 at an edge SHALL force IDLE, clear accumulator and counters, AVG_OUT=0, SUM_OUT=0, AVG_VALID=0, BUSY=0.
REQ-027 Reset mid-block SHALL discard the partial sum with no AVG_VALID pulse; reset has priority over START.

Structure
REQ-028 Package spgd_pkg SHALL hold ADC_WIDTH, MAX_LOG2_N defaults and the FSM state typedef.
REQ-029 Rounding/saturating shift SHALL be sub-module avg_round_sat (combinational; sum, log2_n in; mean out).
REQ-030 FSM, counters and accumulator SHALL live in adc_block_average.

Verification
REQ-031 Constant 12'h800, LOG2_N=10, SETTLE=0, START at edge k -> AVG_VALID high only in cycle after edge k+1025, AVG_OUT=12'h800, SUM_OUT=22'h200000.
REQ-032 Samples alternating 0,1 from ACCUM entry, LOG2_N=1 -> sum 1, AVG_OUT=1 (round-half-up); LOG2_N=0 with sample 12'h123 -> AVG_OUT=12'h123.
REQ-033 Constant 12'hFFF, LOG2_N=4 -> SUM_OUT=16*4095=65520, AVG_OUT=12'hFFF (saturation path, no wrap).
REQ-034 SETTLE=5, first 5 samples 12'hFFF then 0, LOG2_N=3 -> AVG_OUT=0; second START pulse during ACCUM -> exactly one AVG_VALID.
REQ-035 CONT=1, LOG2_N=2, ramp 0,1,2,... -> consecutive results 2 (sum 6) then 6 (sum 22) with pulses 5 cycles apart.
REQ-036 RST_N=0 for one edge at sample 500 of a 1024-block -> BUSY=0 next cycle, no AVG_VALID, outputs 0; new START then completes normally.
